// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Fetch FSM states, word width, PC step, default NOP.
package cpu_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

  localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR =
    32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_OUT,
    S_FAULT
  } fetch_state_t;

  function automatic logic is_aligned(
    input logic [INSTR_W-1:0] addr
  );
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait counter: counts enabled cycles, clears on clear/reset.
// Ports: clock, reset, clear, enable in; expire out (count at LIMIT-1).
module fetch_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  assign expire = (count == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch control: PC next-value, imem req/ack, decode valid/ready.
// Ports: clock/reset, estado_pc/prox_instrucao, mem_*, instr*, desvio, fault.
module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR =
    DEFAULT_NOP_INSTR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] estado_pc,
  output logic [INSTR_W-1:0] prox_instrucao,
  output logic               mem_req,
  output logic [INSTR_W-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instrucao,
  output logic [INSTR_W-1:0] instr_pc,
  output logic               instr_valid,
  input  logic               decode_ready,
  input  logic               desvio,
  input  logic [INSTR_W-1:0] alvo_desvio,
  output logic               fetch_fault
);

  fetch_state_t state;

  logic aligned;
  logic in_req;
  logic ack_hit;
  logic accept;
  logic expire;
  logic misalign;
  logic timeout;

  assign aligned = is_aligned(estado_pc);
  assign in_req  = !reset && (state == S_REQ);

  // No request is raised for an unaligned PC.
  assign mem_req  = in_req && aligned;
  assign mem_addr = estado_pc;

  // An ack only counts while our request is up.
  assign ack_hit  = mem_req && mem_ack;
  assign misalign = in_req && !aligned;
  assign timeout  = mem_req && !mem_ack && expire;

  assign accept = !reset
               && (state == S_OUT)
               && decode_ready;

  // PC loads every clock; holding means echoing it.
  always_comb begin
    prox_instrucao = estado_pc;
    if (reset) begin
      prox_instrucao = '0;
    end else if (accept) begin
      prox_instrucao = desvio
                     ? alvo_desvio
                     : estado_pc + PC_STEP;
    end
  end

  fetch_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clock  (clock),
    .reset  (reset),
    .clear  (!mem_req || mem_ack),
    .enable (mem_req && !mem_ack),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      instr_valid <= 1'b0;
      instrucao   <= NOP_INSTR;
      instr_pc    <= '0;
      fetch_fault <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_REQ;
        end
        S_REQ: begin
          unique case (1'b1)
            misalign, timeout: begin
              state       <= S_FAULT;
              fetch_fault <= 1'b1;
              instr_valid <= 1'b0;
              instrucao   <= NOP_INSTR;
            end
            ack_hit: begin
              state       <= S_OUT;
              instr_valid <= 1'b1;
              instrucao   <= mem_rdata;
              instr_pc    <= estado_pc;
            end
            default: begin
              state <= S_REQ;
            end
          endcase
        end
        S_OUT: begin
          if (decode_ready) begin
            state       <= S_REQ;
            instr_valid <= 1'b0;
          end
        end
        S_FAULT: begin
          state       <= S_FAULT;
          fetch_fault <= 1'b1;
          instr_valid <= 1'b0;
          instrucao   <= NOP_INSTR;
        end
        default: begin
          state <= S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a PC register model.
// Inputs driven at negedge, outputs sampled 1ns later.
module tb_instr_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] estado_pc = 32'h0;
  logic [31:0] prox_instrucao;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] instrucao;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        decode_ready = 1'b0;
  logic        desvio = 1'b0;
  logic [31:0] alvo_desvio = 32'h0;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_ctrl #(
    .TIMEOUT_CYCLES (16),
    .NOP_INSTR      (32'h0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .estado_pc      (estado_pc),
    .prox_instrucao (prox_instrucao),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instrucao      (instrucao),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .decode_ready   (decode_ready),
    .desvio         (desvio),
    .alvo_desvio    (alvo_desvio),
    .fetch_fault    (fetch_fault)
  );

  always #5 clock = ~clock;

  // PC register: loads prox_instrucao every clock.
  always @(posedge clock) estado_pc <= prox_instrucao;

  task automatic step;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE0001;
    #1;
    n_cmp++;
    if (prox_instrucao !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_prox got %h want 0", prox_instrucao);
    end
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_req got %b want 0", mem_req);
    end
    n_cmp++;
    if (instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_flags got v=%b f=%b want 0 0",
               instr_valid, fetch_fault);
    end
    n_cmp++;
    if (instrucao !== 32'h0 || instr_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_regs got %h/%h want 0/0",
               instrucao, instr_pc);
    end
    step();
    mem_ack = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || prox_instrucao !== 32'h0) begin
      n_bad++;
      $display("FAIL idle_cycle got req=%b prox=%h want 0/0",
               mem_req, prox_instrucao);
    end
    step();
  endtask

  task automatic test_basic;
    mem_ack = 1'b1;
    mem_rdata = 32'h20080005;
    #1;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL basic_req got %b/%h want 1/0",
               mem_req, mem_addr);
    end
    step();
    mem_ack = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_valid got %b want 1", instr_valid);
    end
    n_cmp++;
    if (instrucao !== 32'h20080005 || instr_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL basic_instr got %h@%h want 20080005@0",
               instrucao, instr_pc);
    end
    decode_ready = 1'b1;
    #1;
    n_cmp++;
    if (prox_instrucao !== 32'h4) begin
      n_bad++;
      $display("FAIL basic_prox got %h want 4", prox_instrucao);
    end
    step();
    decode_ready = 1'b0;
  endtask

  task automatic test_wait;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h8C090010;
      end
      #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h4
          || prox_instrucao !== 32'h4) begin
        n_bad++;
        $display("FAIL wait_%0d got req=%b addr=%h prox=%h want 1/4/4",
                 i, mem_req, mem_addr, prox_instrucao);
      end
      step();
    end
    mem_ack = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b1 || instrucao !== 32'h8C090010
        || instr_pc !== 32'h4) begin
      n_bad++;
      $display("FAIL wait_out got v=%b %h@%h want 1 8c090010@4",
               instr_valid, instrucao, instr_pc);
    end
    n_cmp++;
    if (estado_pc !== 32'h4) begin
      n_bad++;
      $display("FAIL wait_pc got %h want 4", estado_pc);
    end
  endtask

  task automatic test_stall_branch;
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 2);
      mem_rdata = 32'hDEADBEEF;
      #1;
      n_cmp++;
      if (instr_valid !== 1'b1 || instrucao !== 32'h8C090010
          || prox_instrucao !== 32'h4) begin
        n_bad++;
        $display("FAIL stall_%0d got v=%b i=%h prox=%h want 1/8c090010/4",
                 i, instr_valid, instrucao, prox_instrucao);
      end
      step();
    end
    mem_ack = 1'b0;
    decode_ready = 1'b1;
    desvio = 1'b1;
    alvo_desvio = 32'h40;
    #1;
    n_cmp++;
    if (prox_instrucao !== 32'h40) begin
      n_bad++;
      $display("FAIL branch_prox got %h want 40", prox_instrucao);
    end
    step();
    decode_ready = 1'b0;
    desvio = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40
        || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL branch_req got req=%b addr=%h v=%b want 1/40/0",
               mem_req, mem_addr, instr_valid);
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++;
      if (mem_req !== 1'b1 || fetch_fault !== 1'b0) begin
        n_bad++;
        $display("FAIL tmo_wait_%0d got req=%b f=%b want 1/0",
                 i, mem_req, fetch_fault);
      end
      step();
    end
    #1;
    n_cmp++;
    if (fetch_fault !== 1'b1 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_fault got f=%b req=%b want 1/0",
               fetch_fault, mem_req);
    end
    n_cmp++;
    if (instr_valid !== 1'b0 || instrucao !== 32'h0
        || prox_instrucao !== 32'h40) begin
      n_bad++;
      $display("FAIL tmo_out got v=%b i=%h prox=%h want 0/0/40",
               instr_valid, instrucao, prox_instrucao);
    end
    mem_ack = 1'b1;
    decode_ready = 1'b1;
    step();
    step();
    #1;
    n_cmp++;
    if (fetch_fault !== 1'b1 || mem_req !== 1'b0
        || estado_pc !== 32'h40) begin
      n_bad++;
      $display("FAIL tmo_sticky got f=%b req=%b pc=%h want 1/0/40",
               fetch_fault, mem_req, estado_pc);
    end
    mem_ack = 1'b0;
    decode_ready = 1'b0;
    reset = 1'b1;
    step();
    #1;
    n_cmp++;
    if (fetch_fault !== 1'b0 || estado_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL tmo_clear got f=%b pc=%h want 0/0",
               fetch_fault, estado_pc);
    end
    reset = 1'b0;
    step();
    step();
    #1;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL tmo_restart got req=%b addr=%h want 1/0",
               mem_req, mem_addr);
    end
  endtask

  task automatic test_misaligned;
    mem_ack = 1'b1;
    mem_rdata = 32'h11111111;
    step();
    mem_ack = 1'b0;
    decode_ready = 1'b1;
    desvio = 1'b1;
    alvo_desvio = 32'h42;
    #1;
    n_cmp++;
    if (prox_instrucao !== 32'h42) begin
      n_bad++;
      $display("FAIL mis_prox got %h want 42", prox_instrucao);
    end
    step();
    decode_ready = 1'b0;
    desvio = 1'b0;
    mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || prox_instrucao !== 32'h42) begin
      n_bad++;
      $display("FAIL mis_noreq got req=%b prox=%h want 0/42",
               mem_req, prox_instrucao);
    end
    step();
    mem_ack = 1'b0;
    #1;
    n_cmp++;
    if (fetch_fault !== 1'b1 || instr_valid !== 1'b0
        || instrucao !== 32'h0) begin
      n_bad++;
      $display("FAIL mis_fault got f=%b v=%b i=%h want 1/0/0",
               fetch_fault, instr_valid, instrucao);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
  endtask

  task automatic test_wrap;
    mem_ack = 1'b1;
    mem_rdata = 32'hAAAA0001;
    step();
    mem_ack = 1'b0;
    decode_ready = 1'b1;
    desvio = 1'b1;
    alvo_desvio = 32'hFFFFFFFC;
    step();
    decode_ready = 1'b0;
    alvo_desvio = 32'h100;
    mem_ack = 1'b1;
    mem_rdata = 32'hBBBB0002;
    #1;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hFFFFFFFC
        || prox_instrucao !== 32'hFFFFFFFC) begin
      n_bad++;
      $display("FAIL wrap_req got req=%b addr=%h prox=%h want 1/fffffffc/fffffffc",
               mem_req, mem_addr, prox_instrucao);
    end
    step();
    mem_ack = 1'b0;
    desvio = 1'b0;
    #1;
    n_cmp++;
    if (instrucao !== 32'hBBBB0002 || instr_pc !== 32'hFFFFFFFC) begin
      n_bad++;
      $display("FAIL wrap_out got %h@%h want bbbb0002@fffffffc",
               instrucao, instr_pc);
    end
    decode_ready = 1'b1;
    #1;
    n_cmp++;
    if (prox_instrucao !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_prox got %h want 0", prox_instrucao);
    end
    step();
    decode_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    mem_ack = 1'b1;
    mem_rdata = 32'h0000C0DE;
    step();
    mem_ack = 1'b0;
    decode_ready = 1'b1;
    step();
    decode_ready = 1'b0;
    step();
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    #1;
    n_cmp++;
    if (prox_instrucao !== 32'h0 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_comb got prox=%h req=%b want 0/0",
               prox_instrucao, mem_req);
    end
    step();
    mem_ack = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || instrucao !== 32'h0
        || instr_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_regs got v=%b i=%h pc=%h want 0/0/0",
               instr_valid, instrucao, instr_pc);
    end
    reset = 1'b0;
    step();
    step();
    #1;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_restart got req=%b addr=%h want 1/0",
               mem_req, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_stall_branch();
    test_timeout();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
